// File: rtl/cmp_led_sequencer.sv
// Scans all 16 operand pairs of a 2-bit comparator into registered RGB LEDs, auto-timed or step-driven.
// Define CMP_SELFCHECK_EN to count comparator results that disagree with the golden {a<=b, a!=b, a>=b}.
module cmp_led_sequencer #(
    parameter int unsigned DWELL_CYCLES  = 50_000_000,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             step_i,
    output logic [1:0]       a_out_o,
    output logic [1:0]       b_out_o,
    input  logic [2:0]       rgb_in_i,
    output logic [2:0]       led_o,
    output logic [3:0]       idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [ERR_W-1:0] err_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DWELL,
        S_DONE
    } state_t;

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned DWELL_W  = $clog2(DWELL_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_CYCLES);

    state_t              state_q;
    logic [3:0]          idx_q;
    logic                manual_q;
    logic [2:0]          led_q;
    logic                busy_q;
    logic                done_q;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic [DWELL_W-1:0]  dwell_cnt_q;

    logic start_ok;
    logic dwell_exit;

    assign start_ok   = start_i && (state_q == S_IDLE || state_q == S_DONE);
    // Auto dwell spans the LED-update cycle plus DWELL_CYCLES further cycles.
    assign dwell_exit = manual_q ? step_i : (dwell_cnt_q == DWELL_LAST);

    // NOTE: every register here is a plain flop assigned with <=, so all of them
    // read the pre-edge values of each other regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            manual_q     <= 1'b0;
            led_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        idx_q    <= '0;
                        manual_q <= mode_i;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        state_q  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    settle_cnt_q <= '0;
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    led_q       <= rgb_in_i;
                    dwell_cnt_q <= '0;
                    state_q     <= S_DWELL;
                end
                S_DWELL: begin
                    if (dwell_exit) begin
                        if (idx_q == 4'd15) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_DRIVE;
                        end
                    end else if (!manual_q) begin
                        dwell_cnt_q <= dwell_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_out_o = idx_q[3:2];
    assign b_out_o = idx_q[1:0];
    assign idx_o   = idx_q;
    assign led_o   = led_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

`ifdef CMP_SELFCHECK_EN
    logic [ERR_W-1:0] err_q;
    logic [2:0]       golden;

    always_comb begin
        golden = {idx_q[3:2] <= idx_q[1:0], idx_q[3:2] != idx_q[1:0], idx_q[3:2] >= idx_q[1:0]};
    end

    // Saturates at all-ones; a fresh scan starts from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else if (start_ok) begin
            err_q <= '0;
        end else if (state_q == S_SAMPLE && rgb_in_i != golden && err_q != '1) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_count_o = err_q;
`else
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_cmp_led_sequencer.sv
// Self-checking bench for cmp_led_sequencer: random comparator tables, random noise on
// start/step/mode, and a time-based reference model of the scan schedule.
module tb_cmp_led_sequencer;

    localparam int DWELL  = 4;
    localparam int SETTLE = 2;
    localparam int ERR_W  = 5;
    localparam int PERIOD = 3 + SETTLE + DWELL;
    localparam int SCAN   = 16 * PERIOD;
    localparam int LED_AT = SETTLE + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic             step;
    logic [1:0]       a_out;
    logic [1:0]       b_out;
    logic [2:0]       rgb_in;
    logic [2:0]       led;
    logic [3:0]       idx;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_count;

    logic [2:0] cmp_tbl [16];
    logic [2:0] obs_led [16];
    logic [2:0] last_led;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Comparator stand-in: answers from a lookup table the bench controls.
    assign rgb_in = cmp_tbl[{a_out, b_out}];

    cmp_led_sequencer #(
        .DWELL_CYCLES (DWELL),
        .SETTLE_CYCLES(SETTLE),
        .ERR_W        (ERR_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .mode_i     (mode),
        .step_i     (step),
        .a_out_o    (a_out),
        .b_out_o    (b_out),
        .rgb_in_i   (rgb_in),
        .led_o      (led),
        .idx_o      (idx),
        .busy_o     (busy),
        .done_o     (done),
        .err_count_o(err_count)
    );

    function automatic logic [2:0] golden(input int k);
        int a;
        int b;
        a = k / 4;
        b = k % 4;
        return {a <= b, a != b, a >= b};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_ideal();
        for (int k = 0; k < 16; k++) cmp_tbl[k] = golden(k);
    endtask

    task automatic load_random();
        for (int k = 0; k < 16; k++) cmp_tbl[k] = 3'($urandom_range(0, 7));
    endtask

    function automatic int expected_err();
        int n;
        int cap;
        n = 0;
        for (int k = 0; k < 16; k++) if (cmp_tbl[k] != golden(k)) n++;
`ifdef CMP_SELFCHECK_EN
        cap = (1 << ERR_W) - 1;
        return (n > cap) ? cap : n;
`else
        cap = n;
        return 0;
`endif
    endfunction

    // Auto scan from a start pulse; model: pair k owns cycles [k*PERIOD, (k+1)*PERIOD).
    task automatic run_auto(input string tag, input bit noise, input int stop_t);
        logic [2:0] prev;
        logic [3:0] e_idx;
        logic [2:0] e_led;
        logic       e_busy;
        logic       e_done;
        int         k;
        int         p;
        prev  = last_led;
        start = 1'b1;
        mode  = 1'b0;
        step  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        start = 1'b0;
        step  = 1'b0;
        for (int t = 0; t <= stop_t; t++) begin
            k      = (t < SCAN) ? t / PERIOD : 15;
            p      = t % PERIOD;
            e_idx  = 4'(k);
            e_busy = (t < SCAN);
            e_done = (t >= SCAN);
            if (t >= SCAN)        e_led = cmp_tbl[15];
            else if (p >= LED_AT) e_led = cmp_tbl[k];
            else if (k == 0)      e_led = prev;
            else                  e_led = cmp_tbl[k-1];
            checks++;
            if ({idx, a_out, b_out, led, busy, done} !== {e_idx, e_idx[3:2], e_idx[1:0], e_led, e_busy, e_done}) begin
                failures++;
                $display("FAIL %s t=%0d: got idx=%0d a=%0d b=%0d led=%b busy=%b done=%b, want idx=%0d led=%b busy=%b done=%b",
                         tag, t, idx, a_out, b_out, led, busy, done, e_idx, e_led, e_busy, e_done);
            end
            if (t < SCAN && p == PERIOD - 1) obs_led[k] = led;
            if (noise && t < SCAN) begin
                start = ($urandom_range(0, 5) == 0);
                step  = 1'($urandom_range(0, 1));
                mode  = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
                step  = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        step  = 1'b0;
        if (stop_t >= SCAN) last_led = cmp_tbl[15];
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        step  = 1'b0;
        load_ideal();
        repeat (3) tick();
        checks++;
        if ({idx, a_out, b_out, led, busy, done, err_count} !== '0) begin
            failures++;
            $display("FAIL reset_values: got idx=%0d a=%0d b=%0d led=%b busy=%b done=%b err=%0d, want all zero",
                     idx, a_out, b_out, led, busy, done, err_count);
        end
        rst  = 1'b0;
        step = 1'b1;
        repeat (5) tick();
        step = 1'b0;
        checks++;
        if ({idx, led, busy, done} !== '0) begin
            failures++;
            $display("FAIL idle_ignores_step: got idx=%0d led=%b busy=%b done=%b, want idle zeros", idx, led, busy, done);
        end
        last_led = 3'b000;
    endtask

    task automatic test_known_values();
        load_ideal();
        run_auto("auto_ideal", 1'b0, SCAN + 5);
        checks++;
        if (obs_led[6] !== 3'b110) begin
            failures++;
            $display("FAIL led_idx6: got %b want 110", obs_led[6]);
        end
        checks++;
        if (obs_led[9] !== 3'b011) begin
            failures++;
            $display("FAIL led_idx9: got %b want 011", obs_led[9]);
        end
        checks++;
        if (obs_led[5] !== 3'b101) begin
            failures++;
            $display("FAIL led_idx5: got %b want 101", obs_led[5]);
        end
        checks++;
        if ({led, idx, done} !== {3'b101, 4'd15, 1'b1}) begin
            failures++;
            $display("FAIL final_ideal: got led=%b idx=%0d done=%b, want led=101 idx=15 done=1", led, idx, done);
        end
        checks++;
        if (err_count !== '0) begin
            failures++;
            $display("FAIL err_ideal: got %0d want 0", err_count);
        end
    endtask

    task automatic test_back_to_back_noise();
        int e_err;
        for (int r = 0; r < 2; r++) begin
            load_random();
            e_err = expected_err();
            run_auto("auto_noise", 1'b1, SCAN + 3);
            checks++;
            if (err_count !== ERR_W'(e_err)) begin
                failures++;
                $display("FAIL err_random run=%0d: got %0d want %0d", r, err_count, e_err);
            end
        end
    endtask

    task automatic test_manual();
        logic [2:0] prev;
        load_random();
        prev  = last_led;
        start = 1'b1;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (led !== prev) begin
            failures++;
            $display("FAIL manual_led_before_sample: got %b want %b", led, prev);
        end
        tick();
        repeat (100) begin
            mode = 1'($urandom_range(0, 1));
            tick();
        end
        checks++;
        if ({idx, led, busy, done} !== {4'd0, cmp_tbl[0], 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL manual_no_step: got idx=%0d led=%b busy=%b done=%b, want idx=0 led=%b busy=1 done=0",
                     idx, led, busy, done, cmp_tbl[0]);
        end
        for (int k = 1; k <= 16; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (k == 16) begin
                checks++;
                if ({idx, led, busy, done} !== {4'd15, cmp_tbl[15], 1'b0, 1'b1}) begin
                    failures++;
                    $display("FAIL manual_done: got idx=%0d led=%b busy=%b done=%b, want idx=15 led=%b busy=0 done=1",
                             idx, led, busy, done, cmp_tbl[15]);
                end
            end else begin
                for (int j = 0; j < 4; j++) begin
                    step = 1'($urandom_range(0, 1));
                    tick();
                end
                step = 1'b0;
                checks++;
                if ({idx, led, busy, done} !== {4'(k), cmp_tbl[k], 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL manual_step%0d: got idx=%0d led=%b busy=%b done=%b, want idx=%0d led=%b busy=1 done=0",
                             k, idx, led, busy, done, k, cmp_tbl[k]);
                end
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        last_led = cmp_tbl[15];
    endtask

    task automatic test_rst_mid_dwell();
        int stop;
        load_random();
        stop = PERIOD * $urandom_range(1, 10) + LED_AT + $urandom_range(0, DWELL - 1);
        run_auto("auto_pre_rst", 1'b0, stop);
        rst = 1'b1;
        tick();
        checks++;
        if ({idx, a_out, b_out, led, busy, done, err_count} !== '0) begin
            failures++;
            $display("FAIL rst_mid_dwell: got idx=%0d led=%b busy=%b done=%b err=%0d, want all zero",
                     idx, led, busy, done, err_count);
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({idx, led, busy, done} !== '0) begin
            failures++;
            $display("FAIL post_rst_idle: got idx=%0d led=%b busy=%b done=%b, want idle zeros", idx, led, busy, done);
        end
        last_led = 3'b000;
        load_ideal();
        run_auto("auto_after_rst", 1'b0, SCAN + 2);
    endtask

    initial begin
        test_reset();
        test_known_values();
        test_back_to_back_noise();
        test_manual();
        test_rst_mid_dwell();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
